// File: rtl/ika2151_pkg.sv
// Shared types and constants for the IKA2151 CPU bus responder.
package ika2151_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, COMMIT, READ} busif_state_t;

    localparam int unsigned STAT_BUSY_BIT   = 7;
    localparam int unsigned STAT_TMRB_BIT   = 1;
    localparam int unsigned STAT_TMRA_BIT   = 0;
    localparam int unsigned BUSY_CYCLES_DEF = 64;
    localparam int unsigned BUSY_CNT_W      = $clog2(BUSY_CYCLES_DEF + 1);

    function automatic int unsigned busy_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    function automatic logic [7:0] status_byte(input logic busy, input logic tmrb, input logic tmra);
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_BUSY_BIT] = busy;
        s[STAT_TMRB_BIT] = tmrb;
        s[STAT_TMRA_BIT] = tmra;
        return s;
    endfunction

endpackage

// File: rtl/ika2151_cpubus_sync.sv
// Multi-stage synchronizer for the asynchronous CPU bus controls.
// Control strobes reset to the idle (high) level, A0 resets low.
module ika2151_cpubus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_EMUCLK,
    input  logic i_RST,
    input  logic i_CS_n,
    input  logic i_WR_n,
    input  logic i_RD_n,
    input  logic i_A0,
    output logic cs_n_s,
    output logic wr_n_s,
    output logic rd_n_s,
    output logic a0_s
);

    localparam logic [3:0] RST_VAL = 4'b1110;

    logic [SYNC_STAGES-1:0][3:0] pipe;

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            pipe <= {SYNC_STAGES{RST_VAL}};
        end else begin
            pipe <= {pipe[SYNC_STAGES-2:0], {i_CS_n, i_WR_n, i_RD_n, i_A0}};
        end
    end

    assign {cs_n_s, wr_n_s, rd_n_s, a0_s} = pipe[SYNC_STAGES-1];

endmodule

// File: rtl/ika2151_cpubus_responder.sv
// YM2151 CPU bus responder: host writes -> register strobes, status reads.
// Optional busy counter enabled by defining IKA2151_BUSY_FLAG_EN.
module ika2151_cpubus_responder
    import ika2151_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = BUSY_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phiM_PCEN_n,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_RD_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    input  logic       i_TIMERA_FLAG,
    input  logic       i_TIMERB_FLAG,
    output logic [7:0] o_D,
    output logic       o_CTRL_OE_n,
    output logic       o_REG_WR,
    output logic [7:0] o_REG_ADDR,
    output logic [7:0] o_REG_DATA,
    output logic       o_BUSY
);

    logic cs_n_s, wr_n_s, rd_n_s, a0_s;
    logic wr_act, rd_act, busy_load;
    logic [7:0] status;

    busif_state_t state;
    logic [7:0]   addr_lat;
    logic [7:0]   d_smp;
    logic         a0_smp;

    ika2151_cpubus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_EMUCLK (i_EMUCLK),
        .i_RST    (i_RST),
        .i_CS_n   (i_CS_n),
        .i_WR_n   (i_WR_n),
        .i_RD_n   (i_RD_n),
        .i_A0     (i_A0),
        .cs_n_s   (cs_n_s),
        .wr_n_s   (wr_n_s),
        .rd_n_s   (rd_n_s),
        .a0_s     (a0_s)
    );

    // Write takes priority when RD and WR are both asserted.
    assign wr_act    = ~cs_n_s & ~wr_n_s;
    assign rd_act    = ~cs_n_s & ~rd_n_s & ~wr_act;
    assign busy_load = (state == WRITE) && !wr_act && a0_smp;
    assign status    = status_byte(o_BUSY, i_TIMERB_FLAG, i_TIMERA_FLAG);

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            state       <= IDLE;
            addr_lat    <= 8'h00;
            d_smp       <= 8'h00;
            a0_smp      <= 1'b0;
            o_REG_WR    <= 1'b0;
            o_REG_ADDR  <= 8'h00;
            o_REG_DATA  <= 8'h00;
            o_D         <= 8'h00;
            o_CTRL_OE_n <= 1'b1;
        end else begin
            o_REG_WR <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_act) begin
                        state  <= WRITE;
                        d_smp  <= i_D;
                        a0_smp <= a0_s;
                    end else if (rd_act) begin
                        state       <= READ;
                        o_CTRL_OE_n <= 1'b0;
                        o_D         <= status;
                    end
                end
                WRITE: begin
                    if (wr_act) begin
                        d_smp  <= i_D;
                        a0_smp <= a0_s;
                    end else begin
                        // Strobe is raised on entry so it is visible for the COMMIT cycle.
                        state <= COMMIT;
                        if (a0_smp) begin
                            o_REG_WR   <= 1'b1;
                            o_REG_ADDR <= addr_lat;
                            o_REG_DATA <= d_smp;
                        end else begin
                            addr_lat <= d_smp;
                        end
                    end
                end
                COMMIT: state <= IDLE;
                READ: begin
                    if (rd_act) begin
                        o_CTRL_OE_n <= 1'b0;
                        o_D         <= status;
                    end else begin
                        state       <= IDLE;
                        o_CTRL_OE_n <= 1'b1;
                        o_D         <= 8'h00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IKA2151_BUSY_FLAG_EN
    localparam int unsigned CNT_W = busy_cnt_w(BUSY_CYCLES);

    logic [CNT_W-1:0] busy_cnt;

    // Reload beats decrement; the flag tracks the next count value.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            busy_cnt <= '0;
            o_BUSY   <= 1'b0;
        end else if (busy_load) begin
            busy_cnt <= CNT_W'(BUSY_CYCLES);
            o_BUSY   <= (BUSY_CYCLES != 0);
        end else if (!i_phiM_PCEN_n && busy_cnt != '0) begin
            busy_cnt <= busy_cnt - CNT_W'(1);
            o_BUSY   <= (busy_cnt != CNT_W'(1));
        end
    end
`else
    logic busy_unused;
    assign busy_unused = i_phiM_PCEN_n ^ busy_load ^ (BUSY_CYCLES == 0);
    assign o_BUSY      = 1'b0;
`endif

endmodule

// File: tb/tb_ika2151_cpubus_responder.sv
// Randomized scoreboard bench for ika2151_cpubus_responder.
module tb_ika2151_cpubus_responder;

    localparam int BUSY_CYCLES = 64;
`ifdef IKA2151_BUSY_FLAG_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pcen_n = 1'b1;
    logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
    logic [7:0] d = 8'h00;
    logic       ta = 1'b0, tb = 1'b0;
    logic [7:0] o_d;
    logic       oe_n, reg_wr, busy;
    logic [7:0] reg_addr, reg_data;

    ika2151_cpubus_responder dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phiM_PCEN_n (pcen_n),
        .i_CS_n        (cs_n),
        .i_WR_n        (wr_n),
        .i_RD_n        (rd_n),
        .i_A0          (a0),
        .i_D           (d),
        .i_TIMERA_FLAG (ta),
        .i_TIMERB_FLAG (tb),
        .o_D           (o_d),
        .o_CTRL_OE_n   (oe_n),
        .o_REG_WR      (reg_wr),
        .o_REG_ADDR    (reg_addr),
        .o_REG_DATA    (reg_data),
        .o_BUSY        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } strobe_t;

    strobe_t    exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         load_at = -1;
    int         since = BUSY_CYCLES;
    bit         busy_m = 1'b0;
    logic [7:0] exp_status = 8'h00;
    logic [7:0] addr_m = 8'h00;
    int         oe_low = 0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // phiM enables arrive at random.
    always @(negedge clk) pcen_n = 1'($urandom);

    // Reference model: busy = fewer than BUSY_CYCLES enables since the last data write.
    always @(posedge clk) begin
        cyc++;
        exp_status = {busy_m, 5'b00000, tb, ta};
        if (!rst) begin
            if (cyc == load_at) since = 0;
            else if (!pcen_n && since < BUSY_CYCLES) since++;
        end
        busy_m = BUSY_EN && (since < BUSY_CYCLES);
    end

    // Monitor: pops expected strobes and checks read data and busy every cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (reg_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(reg_wr), 32'd0);
                end else begin
                    strobe_t e;
                    e = exp_q.pop_front();
                    check("strobe_addr", 32'(reg_addr), 32'(e.addr));
                    check("strobe_data", 32'(reg_data), 32'(e.data));
                    check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (!oe_n) begin
                oe_low++;
                check("status", 32'(o_d), 32'(exp_status));
            end else begin
                check("d_idle", 32'(o_d), 32'd0);
            end
            check("busy", 32'(busy), 32'(busy_m));
        end
    end

    task automatic bus_write(input logic a0v, input logic [7:0] dv, input bit end_cs, input bit with_rd);
        int rel;
        int oe0;
        strobe_t e;
        @(negedge clk);
        a0 = a0v; d = dv; cs_n = 1'b0; wr_n = 1'b0; rd_n = !with_rd;
        oe0 = oe_low;
        repeat (3 + $urandom_range(0, 3)) @(negedge clk);
        rel = cyc;
        if (end_cs) cs_n = 1'b1;
        else begin wr_n = 1'b1; rd_n = 1'b1; end
        if (a0v) begin
            e.addr = addr_m; e.data = dv; e.cyc = rel + 3;
            exp_q.push_back(e);
            load_at = rel + 3;
        end else begin
            addr_m = dv;
        end
        repeat (3) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        repeat (3) @(negedge clk);
        if (with_rd) check("oe_during_write", 32'(oe_low - oe0), 32'd0);
    endtask

    task automatic bus_read(input int n);
        int oe0;
        @(negedge clk);
        oe0 = oe_low;
        a0 = 1'($urandom); cs_n = 1'b0; rd_n = 1'b0;
        repeat (n) @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (4) @(negedge clk);
        check("oe_cycles", 32'(oe_low - oe0), 32'(n));
    endtask

    task automatic do_reset(input bit mid_write);
        @(negedge clk);
        if (mid_write) begin
            a0 = 1'b1; d = 8'($urandom); cs_n = 1'b0; wr_n = 1'b0;
            repeat (2) @(negedge clk);
        end
        rst = 1'b1;
        exp_q.delete();
        addr_m = 8'h00; since = BUSY_CYCLES; busy_m = 1'b0; load_at = -1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_d", 32'(o_d), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_data", 32'(reg_data), 32'd0);
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b0);
        repeat (3) @(negedge clk);

        // Address then data write; then poll status long enough for busy to expire.
        bus_write(1'b0, 8'h18, 1'b0, 1'b0);
        bus_write(1'b1, 8'hFF, 1'b0, 1'b0);
        bus_read(200);

        // Back-to-back data writes share the latched address.
        bus_write(1'b0, 8'h08, 1'b0, 1'b0);
        bus_write(1'b1, 8'h08, 1'b0, 1'b0);
        bus_write(1'b1, 8'h7F, 1'b1, 1'b0);

        // Timer flags in status; RD and WR low together must be a write.
        ta = 1'b1; tb = 1'b1;
        repeat (150) @(negedge clk);
        bus_read(5);
        bus_write(1'b1, 8'h55, 1'b0, 1'b1);
        bus_write(1'b1, 8'hA5, 1'b1, 1'b1);

        // Reset during busy and mid-write.
        bus_write(1'b1, 8'h33, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        do_reset(1'b1);
        repeat (10) @(negedge clk);
        bus_write(1'b1, 8'h44, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ta = 1'($urandom); tb = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       bus_write(1'b0, 8'($urandom), 1'($urandom), 1'b0);
                1, 2:    bus_write(1'b1, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
                default: bus_read($urandom_range(1, 8));
            endcase
        end

        repeat (10) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
